// File: rtl/pll_rst_ctrl.sv
// PLL lock qualifier and staggered reset sequencer.
// Runs on the free-running board clock; all outputs are registered.
module pll_rst_ctrl #(
    parameter int N_DOM       = 3,
    parameter int STABLE_CYC  = 1024,
    parameter int STAGGER_CYC = 16,
    parameter int TIMEOUT_CYC = 1000000,
    parameter int PLL_RST_CYC = 64,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pll_lock,
    output logic             pll_rst,
    output logic [N_DOM-1:0] sys_rst_n,
    output logic             sys_ready,
    output logic [CNT_W-1:0] lock_loss_cnt,
    output logic [3:0]       retry_cnt
);

    localparam int MAX_AB =
        (TIMEOUT_CYC > STABLE_CYC) ? TIMEOUT_CYC : STABLE_CYC;
    localparam int MAX_CD =
        (STAGGER_CYC > PLL_RST_CYC) ? STAGGER_CYC : PLL_RST_CYC;
    localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CW = $clog2(MAX_CYC) + 1;

    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] ST_LAST  = CW'(STABLE_CYC - 2);
    localparam logic [CW-1:0] SG_LAST  = CW'(STAGGER_CYC - 1);
    localparam logic [CW-1:0] PR_LAST  = CW'(PLL_RST_CYC - 1);

    typedef enum logic [2:0] {
        WAIT_LOCK,
        PLL_RST,
        STABLE,
        RELEASE,
        RUN
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sync1_q, lock_s;
    logic             pll_rst_d;
    logic [N_DOM-1:0] rst_d, rel_next;
    logic             ready_d;
    logic [CNT_W-1:0] loss_d;
    logic [3:0]       retry_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            lock_s  <= 1'b0;
        end else begin
            sync1_q <= pll_lock;
            lock_s  <= sync1_q;
        end
    end

    // Next release pattern: one more low-order bit set, never out of order.
    assign rel_next = (sys_rst_n << 1) | N_DOM'(1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pll_rst_d = pll_rst;
        rst_d     = sys_rst_n;
        ready_d   = sys_ready;
        loss_d    = lock_loss_cnt;
        retry_d   = retry_cnt;
        unique case (state_q)
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == TO_LAST) begin
                    state_d   = PLL_RST;
                    cnt_d     = '0;
                    pll_rst_d = 1'b1;
                    if (retry_cnt != 4'hf)
                        retry_d = retry_cnt + 4'd1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            PLL_RST: begin
                if (cnt_q == PR_LAST) begin
                    state_d   = WAIT_LOCK;
                    cnt_d     = '0;
                    pll_rst_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            STABLE: begin
                // The entry edge already counts as the first stable sample.
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == ST_LAST) begin
                    rst_d = rel_next;
                    cnt_d = '0;
                    if (&rel_next) begin
                        ready_d = 1'b1;
                        state_d = RUN;
                    end else begin
                        state_d = RELEASE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RELEASE: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                    rst_d   = '0;
                end else if (cnt_q == SG_LAST) begin
                    rst_d = rel_next;
                    cnt_d = '0;
                    if (&rel_next) begin
                        ready_d = 1'b1;
                        state_d = RUN;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                    rst_d   = '0;
                    ready_d = 1'b0;
                    if (lock_loss_cnt != '1)
                        loss_d = lock_loss_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_d   = WAIT_LOCK;
                cnt_d     = '0;
                rst_d     = '0;
                ready_d   = 1'b0;
                pll_rst_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= WAIT_LOCK;
            cnt_q         <= '0;
            pll_rst       <= 1'b0;
            sys_rst_n     <= '0;
            sys_ready     <= 1'b0;
            lock_loss_cnt <= '0;
            retry_cnt     <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pll_rst       <= pll_rst_d;
            sys_rst_n     <= rst_d;
            sys_ready     <= ready_d;
            lock_loss_cnt <= loss_d;
            retry_cnt     <= retry_d;
        end
    end

endmodule

// File: tb/tb_pll_rst_ctrl.sv
// Directed bench for pll_rst_ctrl: default-parameter reset check plus
// small-parameter bring-up, glitch, loss, timeout and saturation scenarios.
module tb_pll_rst_ctrl;

    logic clk;
    logic rst_n_d, lock_d;
    logic rst_n, lock;

    logic       pll_rst_d;
    logic [2:0] sys_rst_n_d;
    logic       sys_ready_d;
    logic [7:0] loss_d;
    logic [3:0] retry_d;

    logic       pll_rst;
    logic [2:0] sys_rst_n;
    logic       sys_ready;
    logic [7:0] loss;
    logic [3:0] retry;

    logic       pll_rst_s;
    logic [2:0] sys_rst_n_s;
    logic       sys_ready_s;
    logic [1:0] loss_s;
    logic [3:0] retry_s;

    int pass_cnt = 0;
    int total_cnt = 0;

    pll_rst_ctrl u_def (
        .clk(clk), .rst_n(rst_n_d), .pll_lock(lock_d),
        .pll_rst(pll_rst_d), .sys_rst_n(sys_rst_n_d),
        .sys_ready(sys_ready_d), .lock_loss_cnt(loss_d),
        .retry_cnt(retry_d)
    );

    pll_rst_ctrl #(
        .N_DOM(3), .STABLE_CYC(8), .STAGGER_CYC(4),
        .TIMEOUT_CYC(100), .PLL_RST_CYC(5), .CNT_W(8)
    ) u_sm (
        .clk(clk), .rst_n(rst_n), .pll_lock(lock),
        .pll_rst(pll_rst), .sys_rst_n(sys_rst_n),
        .sys_ready(sys_ready), .lock_loss_cnt(loss),
        .retry_cnt(retry)
    );

    pll_rst_ctrl #(
        .N_DOM(3), .STABLE_CYC(8), .STAGGER_CYC(4),
        .TIMEOUT_CYC(100), .PLL_RST_CYC(5), .CNT_W(2)
    ) u_sat (
        .clk(clk), .rst_n(rst_n), .pll_lock(lock),
        .pll_rst(pll_rst_s), .sys_rst_n(sys_rst_n_s),
        .sys_ready(sys_ready_s), .lock_loss_cnt(loss_s),
        .retry_cnt(retry_s)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: sim time exceeded, passed=%0d total=%0d",
                 pass_cnt, total_cnt);
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        lock  = 1'b0;
        tick(2);
        rst_n = 1'b1;
    endtask

    // Lock was raised right after the current edge E0; lock_s is first
    // sampled at E3, so releases land on E10, E14, E18.
    task automatic check_release_seq(input string tag,
                                     input logic [7:0] exp_loss);
        tick(9);
        total_cnt++;
        if (sys_rst_n !== 3'b000) $display("FAIL %s_e9: got %b want 000", tag, sys_rst_n);
        else pass_cnt++;
        tick(1);
        total_cnt++;
        if (sys_rst_n !== 3'b001) $display("FAIL %s_e10: got %b want 001", tag, sys_rst_n);
        else pass_cnt++;
        tick(3);
        total_cnt++;
        if (sys_rst_n !== 3'b001) $display("FAIL %s_e13: got %b want 001", tag, sys_rst_n);
        else pass_cnt++;
        tick(1);
        total_cnt++;
        if ({sys_rst_n, sys_ready} !== 4'b0110)
            $display("FAIL %s_e14: got %b/%b want 011/0", tag, sys_rst_n, sys_ready);
        else pass_cnt++;
        tick(3);
        total_cnt++;
        if ({sys_rst_n, sys_ready} !== 4'b0110)
            $display("FAIL %s_e17: got %b/%b want 011/0", tag, sys_rst_n, sys_ready);
        else pass_cnt++;
        tick(1);
        total_cnt++;
        if ({sys_rst_n, sys_ready} !== 4'b1111)
            $display("FAIL %s_e18: got %b/%b want 111/1", tag, sys_rst_n, sys_ready);
        else pass_cnt++;
        total_cnt++;
        if (loss !== exp_loss)
            $display("FAIL %s_loss: got %0d want %0d", tag, loss, exp_loss);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rst_n_d = 1'b0;
        lock_d  = 1'b0;
        rst_n   = 1'b0;
        lock    = 1'b0;
        tick(2);
        for (int i = 0; i < 6; i++) begin
            lock_d = ~lock_d;
            tick(4);
            total_cnt++;
            if ({pll_rst_d, sys_rst_n_d, sys_ready_d, loss_d, retry_d} !== 17'h0)
                $display("FAIL reset_def_%0d: got pll=%b rst=%b rdy=%b loss=%0d retry=%0d want all 0",
                         i, pll_rst_d, sys_rst_n_d, sys_ready_d, loss_d, retry_d);
            else pass_cnt++;
        end
        total_cnt++;
        if ({pll_rst, sys_rst_n, sys_ready, loss, retry} !== 17'h0)
            $display("FAIL reset_sm: got pll=%b rst=%b rdy=%b want all 0",
                     pll_rst, sys_rst_n, sys_ready);
        else pass_cnt++;
    endtask

    task automatic test_bringup();
        do_reset();
        lock = 1'b1;
        check_release_seq("bringup", 8'd0);
    endtask

    task automatic test_glitch();
        do_reset();
        lock = 1'b1;
        tick(4);
        lock = 1'b0;
        tick(3);
        lock = 1'b1;
        tick(2);
        total_cnt++;
        if (sys_rst_n !== 3'b000) $display("FAIL glitch_e9: got %b want 000", sys_rst_n);
        else pass_cnt++;
        tick(7);
        total_cnt++;
        if (sys_rst_n !== 3'b000) $display("FAIL glitch_e16: got %b want 000", sys_rst_n);
        else pass_cnt++;
        tick(1);
        total_cnt++;
        if (sys_rst_n !== 3'b001) $display("FAIL glitch_e17: got %b want 001", sys_rst_n);
        else pass_cnt++;
        tick(4);
        total_cnt++;
        if (sys_rst_n !== 3'b011) $display("FAIL glitch_e21: got %b want 011", sys_rst_n);
        else pass_cnt++;
        tick(4);
        total_cnt++;
        if ({sys_rst_n, sys_ready, loss} !== {3'b111, 1'b1, 8'd0})
            $display("FAIL glitch_e25: got %b/%b/%0d want 111/1/0", sys_rst_n, sys_ready, loss);
        else pass_cnt++;
    endtask

    task automatic test_run_loss();
        lock = 1'b0;
        tick(2);
        total_cnt++;
        if ({sys_rst_n, sys_ready} !== 4'b1111)
            $display("FAIL loss_f2: got %b/%b want 111/1", sys_rst_n, sys_ready);
        else pass_cnt++;
        tick(1);
        total_cnt++;
        if ({sys_rst_n, sys_ready, loss} !== {3'b000, 1'b0, 8'd1})
            $display("FAIL loss_f3: got %b/%b/%0d want 000/0/1", sys_rst_n, sys_ready, loss);
        else pass_cnt++;
        lock = 1'b1;
        check_release_seq("relock", 8'd1);
    endtask

    task automatic test_release_loss();
        lock = 1'b0;
        tick(3);
        total_cnt++;
        if (loss !== 8'd2) $display("FAIL rel_loss_run: got %0d want 2", loss);
        else pass_cnt++;
        lock = 1'b1;
        tick(14);
        total_cnt++;
        if (sys_rst_n !== 3'b011) $display("FAIL rel_loss_mid: got %b want 011", sys_rst_n);
        else pass_cnt++;
        lock = 1'b0;
        tick(2);
        total_cnt++;
        if (sys_rst_n !== 3'b011) $display("FAIL rel_loss_h2: got %b want 011", sys_rst_n);
        else pass_cnt++;
        tick(1);
        total_cnt++;
        if ({sys_rst_n, sys_ready, loss} !== {3'b000, 1'b0, 8'd2})
            $display("FAIL rel_loss_h3: got %b/%b/%0d want 000/0/2", sys_rst_n, sys_ready, loss);
        else pass_cnt++;
    endtask

    task automatic test_timeout();
        int exp_retry;
        do_reset();
        for (int n = 1; n <= 17; n++) begin
            exp_retry = (n > 15) ? 15 : n;
            tick(99);
            total_cnt++;
            if (pll_rst !== 1'b0) $display("FAIL to_pre_%0d: got %b want 0", n, pll_rst);
            else pass_cnt++;
            tick(1);
            total_cnt++;
            if ({pll_rst, retry} !== {1'b1, 4'(exp_retry)})
                $display("FAIL to_start_%0d: got %b/%0d want 1/%0d", n, pll_rst, retry, exp_retry);
            else pass_cnt++;
            tick(4);
            total_cnt++;
            if (pll_rst !== 1'b1) $display("FAIL to_last_%0d: got %b want 1", n, pll_rst);
            else pass_cnt++;
            tick(1);
            total_cnt++;
            if ({pll_rst, sys_rst_n} !== 4'b0000)
                $display("FAIL to_end_%0d: got %b/%b want 0/000", n, pll_rst, sys_rst_n);
            else pass_cnt++;
        end
    endtask

    task automatic test_saturation();
        int exp_sat;
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            exp_sat = (i > 3) ? 3 : i;
            lock = 1'b1;
            tick(18);
            total_cnt++;
            if (sys_ready_s !== 1'b1) $display("FAIL sat_ready_%0d: got %b want 1", i, sys_ready_s);
            else pass_cnt++;
            lock = 1'b0;
            tick(3);
            total_cnt++;
            if (loss_s !== 2'(exp_sat))
                $display("FAIL sat_loss_%0d: got %0d want %0d", i, loss_s, exp_sat);
            else pass_cnt++;
            total_cnt++;
            if (loss !== 8'(i)) $display("FAIL wide_loss_%0d: got %0d want %0d", i, loss, i);
            else pass_cnt++;
        end
    endtask

    task automatic test_async_reset();
        lock = 1'b1;
        tick(14);
        total_cnt++;
        if (sys_rst_n_s !== 3'b011) $display("FAIL ar_mid: got %b want 011", sys_rst_n_s);
        else pass_cnt++;
        #5;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({pll_rst_s, sys_rst_n_s, sys_ready_s, loss_s, retry_s} !== 11'h0)
            $display("FAIL ar_sat: got rst=%b rdy=%b loss=%0d want 000/0/0",
                     sys_rst_n_s, sys_ready_s, loss_s);
        else pass_cnt++;
        total_cnt++;
        if ({pll_rst, sys_rst_n, sys_ready, loss, retry} !== 17'h0)
            $display("FAIL ar_sm: got rst=%b rdy=%b loss=%0d want 000/0/0",
                     sys_rst_n, sys_ready, loss);
        else pass_cnt++;
        tick(2);
    endtask

    initial begin
        test_reset();
        test_bringup();
        test_glitch();
        test_run_loss();
        test_release_loss();
        test_timeout();
        test_saturation();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
